// File: rtl/batcharger_adc_sequencer_if.sv
// ---------------------------------------------------------------------------
// batcharger_adc_sequencer_if
// Handshake bundle between the ADC sequencer and the shared 8-bit SAR ADC.
//   adc_start : sequencer -> ADC, 1-cycle start-of-conversion pulse
//   adc_sel   : sequencer -> analog mux, 00=V 01=I 10=T 11=none
//   adc_data  : ADC -> sequencer, conversion result (valid with adc_eoc)
//   adc_eoc   : ADC -> sequencer, 1-cycle end-of-conversion pulse
// master = sequencer side, slave = ADC / mux side.
// ---------------------------------------------------------------------------
interface batcharger_adc_sequencer_if;
    logic       adc_start;
    logic [1:0] adc_sel;
    logic [7:0] adc_data;
    logic       adc_eoc;

    modport master (
        output adc_start,
        output adc_sel,
        input  adc_data,
        input  adc_eoc
    );

    modport slave (
        input  adc_start,
        input  adc_sel,
        output adc_data,
        output adc_eoc
    );
endinterface

// File: rtl/batcharger_adc_sequencer.sv
// ---------------------------------------------------------------------------
// batcharger_adc_sequencer
// Time-multiplexes one shared SAR ADC across the battery voltage, current and
// temperature channels in V->I->T round-robin order, skipping channels whose
// monitor enable is low. Each published code is the truncated mean of
// 2**AVG_LOG2 conversions.
// Ports:
//   clk, rstz          : clock (rising edge), asynchronous active-low reset
//   en                 : sequencer enable
//   vmonen/imonen/tmonen : per-channel monitor enables
//   adc (master)       : start/select/data/eoc handshake to the ADC
//   vbat/ibat/tbat     : latest averaged codes (hold when not updated)
//   vtok               : vbat and tbat both updated since en rose
//   data_upd           : 1-cycle pulse after any code register updates
//   adc_err            : sticky conversion timeout flag
//   dvdd/dgnd          : supply pins, no logic function
// ---------------------------------------------------------------------------
module batcharger_adc_sequencer #(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int AVG_LOG2    = 1
) (
    input  logic                              clk,
    input  logic                              rstz,
    input  logic                              en,
    input  logic                              vmonen,
    input  logic                              imonen,
    input  logic                              tmonen,
    batcharger_adc_sequencer_if.master        adc,
    output logic [7:0]                        vbat,
    output logic [7:0]                        ibat,
    output logic [7:0]                        tbat,
    output logic                              vtok,
    output logic                              data_upd,
    output logic                              adc_err,
    inout  wire                               dvdd,
    inout  wire                               dgnd
);

    typedef enum logic [1:0] {IDLE, SETTLE, START, WAIT} state_t;

    localparam logic [1:0] CH_V    = 2'd0;
    localparam logic [1:0] CH_I    = 2'd1;
    localparam logic [1:0] CH_T    = 2'd2;
    localparam logic [1:0] CH_NONE = 2'd3;

    localparam logic [2:0] NSAMP        = 3'(1 << AVG_LOG2);
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q;
    logic [1:0] sel_q;
    logic [1:0] ptr_q;          // first channel to consider on the next pick
    logic [7:0] settle_cnt_q;
    logic [7:0] tmo_cnt_q;
    logic [9:0] accum_q;
    logic [2:0] cnt_q;
    logic       start_q;
    logic       seen_v_q;
    logic       seen_t_q;
    logic       vtok_q;
    logic       upd_q;
    logic       err_q;
    logic [7:0] vbat_q;
    logic [7:0] ibat_q;
    logic [7:0] tbat_q;

    logic [3:0] mon_vec;
    logic       sel_live;
    logic [9:0] accum_d;
    logic [2:0] cnt_d;
    logic [7:0] avg_d;
    logic [2:0] cand;
    logic [1:0] pick_ch;
    logic       pick_ok;

    // Supply pins carry no logic; tie them off so they are not flagged unused.
    wire unused_supply = dvdd ^ dgnd;

    // Bit 3 pads the "none" select so sel_q can index directly.
    assign mon_vec  = {1'b0, tmonen, imonen, vmonen};
    assign sel_live = mon_vec[sel_q];
    assign accum_d  = accum_q + {2'b00, adc.adc_data};
    assign cnt_d    = cnt_q + 3'd1;
    assign avg_d    = 8'(accum_d >> AVG_LOG2);

    // Round-robin pick: scan ptr, ptr+1, ptr+2 (mod 3). The scan runs from the
    // farthest candidate down so the nearest enabled channel wins.
    always_comb begin
        pick_ok = 1'b0;
        pick_ch = CH_NONE;
        cand    = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (mon_vec[cand[1:0]]) begin
                pick_ok = 1'b1;
                pick_ch = cand[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q      <= IDLE;
            sel_q        <= CH_NONE;
            ptr_q        <= CH_V;
            settle_cnt_q <= 8'd0;
            tmo_cnt_q    <= 8'd0;
            accum_q      <= 10'd0;
            cnt_q        <= 3'd0;
            start_q      <= 1'b0;
            seen_v_q     <= 1'b0;
            seen_t_q     <= 1'b0;
            vtok_q       <= 1'b0;
            upd_q        <= 1'b0;
            err_q        <= 1'b0;
            vbat_q       <= 8'h00;
            ibat_q       <= 8'h00;
            tbat_q       <= 8'h00;
        end else begin
            upd_q   <= 1'b0;
            start_q <= 1'b0;
            if (!en) begin
                // Code registers and the sticky error deliberately hold.
                state_q  <= IDLE;
                sel_q    <= CH_NONE;
                accum_q  <= 10'd0;
                cnt_q    <= 3'd0;
                seen_v_q <= 1'b0;
                seen_t_q <= 1'b0;
                vtok_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pick_ok) begin
                            sel_q        <= pick_ch;
                            ptr_q        <= (pick_ch == CH_T) ? CH_V : pick_ch + 2'd1;
                            settle_cnt_q <= 8'd0;
                            state_q      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= START;
                            start_q <= 1'b1;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 8'd1;
                        end
                    end
                    START: begin
                        tmo_cnt_q <= 8'd0;
                        state_q   <= WAIT;
                    end
                    WAIT: begin
                        // eoc is tested first so it wins over a same-cycle timeout.
                        if (adc.adc_eoc) begin
                            if (!sel_live) begin
                                // Channel disabled mid-conversion: drop the result.
                                accum_q <= 10'd0;
                                cnt_q   <= 3'd0;
                                sel_q   <= CH_NONE;
                                state_q <= IDLE;
                            end else if (cnt_d == NSAMP) begin
                                case (sel_q)
                                    CH_V: begin
                                        vbat_q   <= avg_d;
                                        seen_v_q <= 1'b1;
                                        vtok_q   <= vtok_q | seen_t_q;
                                    end
                                    CH_I: ibat_q <= avg_d;
                                    CH_T: begin
                                        tbat_q   <= avg_d;
                                        seen_t_q <= 1'b1;
                                        vtok_q   <= vtok_q | seen_v_q;
                                    end
                                    default: ;
                                endcase
                                upd_q   <= 1'b1;
                                accum_q <= 10'd0;
                                cnt_q   <= 3'd0;
                                sel_q   <= CH_NONE;
                                state_q <= IDLE;
                            end else begin
                                // More samples needed: reconvert without re-settling.
                                accum_q <= accum_d;
                                cnt_q   <= cnt_d;
                                start_q <= 1'b1;
                                state_q <= START;
                            end
                        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                            err_q   <= 1'b1;
                            accum_q <= 10'd0;
                            cnt_q   <= 3'd0;
                            sel_q   <= CH_NONE;
                            state_q <= IDLE;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign adc.adc_start = start_q;
    assign adc.adc_sel   = sel_q;
    assign vbat          = vbat_q;
    assign ibat          = ibat_q;
    assign tbat          = tbat_q;
    assign vtok          = vtok_q;
    assign data_upd      = upd_q;
    assign adc_err       = err_q;

endmodule

// File: tb/tb_batcharger_adc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_batcharger_adc_sequencer
// Behavioural ADC answers each adc_start after EOC_DLY cycles with a code
// derived from a per-channel base value; every completed average is pushed to
// a scoreboard and popped when the DUT pulses data_upd. A negedge monitor
// also tracks round-robin order, settle length, restart spacing, timeout
// length and vtok.
// ---------------------------------------------------------------------------
module tb_batcharger_adc_sequencer;
    localparam int SETTLE  = 4;
    localparam int TMO     = 64;
    localparam int AVG     = 1;
    localparam int NS      = 1 << AVG;
    localparam int EOC_DLY = 3;

    logic       clk    = 1'b0;
    logic       rstz   = 1'b0;
    logic       en     = 1'b0;
    logic       vmonen = 1'b0;
    logic       imonen = 1'b0;
    logic       tmonen = 1'b0;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vtok;
    logic       data_upd;
    logic       adc_err;
    wire        dvdd = 1'b1;
    wire        dgnd = 1'b0;

    batcharger_adc_sequencer_if adc();

    batcharger_adc_sequencer #(
        .SETTLE_CYC (SETTLE),
        .TIMEOUT_CYC(TMO),
        .AVG_LOG2   (AVG)
    ) dut (
        .clk     (clk),
        .rstz    (rstz),
        .en      (en),
        .vmonen  (vmonen),
        .imonen  (imonen),
        .tmonen  (tmonen),
        .adc     (adc),
        .vbat    (vbat),
        .ibat    (ibat),
        .tbat    (tbat),
        .vtok    (vtok),
        .data_upd(data_upd),
        .adc_err (adc_err),
        .dvdd    (dvdd),
        .dgnd    (dgnd)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks   = 0;
    int         failures = 0;
    int         upd_cnt  = 0;
    int         n_i_sel  = 0;
    logic [7:0] base [4];
    logic       no_eoc_i = 1'b0;
    logic [9:0] sb [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] next_en(input logic [1:0] last, input logic [3:0] m);
        logic [1:0] c;
        c = last;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (m[c]) return c;
        end
        return 2'd3;
    endfunction

    // ADC model and scoreboard producer.
    initial begin : adc_model
        int         pend_cnt;
        logic [1:0] pend_ch;
        logic [9:0] acc [4];
        int         n [4];
        logic [7:0] d;
        pend_cnt     = 0;
        pend_ch      = 2'd0;
        adc.adc_eoc  = 1'b0;
        adc.adc_data = 8'h00;
        for (int c = 0; c < 4; c++) begin acc[c] = 10'd0; n[c] = 0; end
        forever begin
            @(negedge clk);
            adc.adc_eoc = 1'b0;
            if (!en || !rstz) begin
                for (int c = 0; c < 4; c++) begin acc[c] = 10'd0; n[c] = 0; end
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    d            = base[pend_ch] + 8'(n[pend_ch]);
                    adc.adc_data = d;
                    adc.adc_eoc  = 1'b1;
                    if (en && rstz) begin
                        acc[pend_ch] = acc[pend_ch] + {2'b00, d};
                        n[pend_ch]++;
                        if (n[pend_ch] == NS) begin
                            sb.push_back({pend_ch, 8'(acc[pend_ch] >> AVG)});
                            acc[pend_ch] = 10'd0;
                            n[pend_ch]   = 0;
                        end
                    end
                end
            end
            if (adc.adc_start) begin
                pend_ch  = adc.adc_sel;
                pend_cnt = (no_eoc_i && pend_ch == 2'd1) ? 0 : EOC_DLY;
            end
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin : monitor
        logic [1:0] prev_sel;
        logic [1:0] prev_ch;
        logic [1:0] cur_ch;
        logic       have_prev;
        logic       started;
        logic       en_prev;
        logic       err_prev;
        logic       seen_v;
        logic       seen_t;
        logic [3:0] mon_snap;
        logic [9:0] e;
        int         settle_n;
        int         n_starts;
        int         last_start;
        prev_sel = 2'd3; prev_ch = 2'd2; cur_ch = 2'd3; have_prev = 1'b1;
        started = 1'b0; en_prev = 1'b0; err_prev = 1'b0; seen_v = 1'b0; seen_t = 1'b0;
        mon_snap = 4'd0; settle_n = 0; n_starts = 0; last_start = 0;
        forever begin
            @(negedge clk);
            if (!rstz) begin
                have_prev = 1'b1; prev_ch = 2'd2; seen_v = 1'b0; seen_t = 1'b0; started = 1'b0;
            end else if (!en) begin
                if (en_prev) have_prev = 1'b0;
                seen_v = 1'b0; seen_t = 1'b0;
            end
            if (prev_sel == 2'd3 && adc.adc_sel != 2'd3) begin
                cur_ch = adc.adc_sel; settle_n = 0; n_starts = 0; started = 1'b0;
                if (cur_ch == 2'd1) n_i_sel++;
                if (have_prev) check_eq("rr_order", 32'(cur_ch), 32'(next_en(prev_ch, mon_snap)));
                have_prev = 1'b1; prev_ch = cur_ch;
                $display("t=%0t select ch=%0d", $time, cur_ch);
            end
            if (adc.adc_start) begin
                if (!started) check_eq("settle_len", 32'(settle_n), 32'(SETTLE));
                else          check_eq("restart_gap", 32'(cyc - last_start), 32'(EOC_DLY + 1));
                started = 1'b1; n_starts++; last_start = cyc;
            end else if (adc.adc_sel != 2'd3 && !started) begin
                settle_n++;
            end
            if (data_upd) begin
                check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("upd_ch", 32'(cur_ch), 32'(e[9:8]));
                    case (e[9:8])
                        2'd0: begin check_eq("vbat", 32'(vbat), 32'(e[7:0])); seen_v = 1'b1; end
                        2'd1: check_eq("ibat", 32'(ibat), 32'(e[7:0]));
                        2'd2: begin check_eq("tbat", 32'(tbat), 32'(e[7:0])); seen_t = 1'b1; end
                        default: ;
                    endcase
                    check_eq("vtok", 32'(vtok), 32'(seen_v && seen_t));
                    check_eq("starts_per_upd", 32'(n_starts), 32'(NS));
                    $display("t=%0t update ch=%0d code=%02h vtok=%0b", $time, e[9:8], e[7:0], vtok);
                end
                upd_cnt++;
            end
            if (adc_err && !err_prev) begin
                check_eq("tmo_len", 32'(cyc - last_start), 32'(TMO + 1));
                $display("t=%0t timeout ch=%0d", $time, cur_ch);
            end
            err_prev = adc_err;
            en_prev  = en;
            prev_sel = adc.adc_sel;
            mon_snap = {1'b0, tmonen, imonen, vmonen};
        end
    end

    task automatic wait_upd(input int n, input int max_cyc);
        int target;
        int k;
        target = upd_cnt + n;
        k = 0;
        while (upd_cnt < target && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (upd_cnt < target) check_eq("wait_upd_bound", 32'(upd_cnt), 32'(target));
    endtask

    initial begin : stim
        logic [7:0] vsave;
        logic [7:0] tsave;
        int         k;
        base[0] = 8'hA3; base[1] = 8'h66; base[2] = 8'h65; base[3] = 8'h00;

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_vbat", 32'(vbat), 32'h00);
        check_eq("rst_ibat", 32'(ibat), 32'h00);
        check_eq("rst_tbat", 32'(tbat), 32'h00);
        check_eq("rst_start", 32'(adc.adc_start), 32'd0);
        check_eq("rst_sel", 32'(adc.adc_sel), 32'd3);
        check_eq("rst_vtok", 32'(vtok), 32'd0);
        check_eq("rst_upd", 32'(data_upd), 32'd0);
        check_eq("rst_err", 32'(adc_err), 32'd0);
        rstz = 1'b1;

        // Current channel disabled: V and T alternate, ibat untouched.
        @(posedge clk); #2;
        en = 1'b1; vmonen = 1'b1; tmonen = 1'b1; imonen = 1'b0;
        wait_upd(4, 600);
        check_eq("p1_no_i_sel", 32'(n_i_sel), 32'd0);
        check_eq("p1_ibat_hold", 32'(ibat), 32'h00);
        check_eq("p1_vbat_trunc", 32'(vbat), 32'hA3);
        check_eq("p1_vtok", 32'(vtok), 32'd1);

        // All channels enabled.
        base[0] = 8'h99;
        imonen  = 1'b1;
        wait_upd(6, 900);
        check_eq("p2_vbat", 32'(vbat), 32'h99);
        check_eq("p2_ibat", 32'(ibat), 32'h66);
        check_eq("p2_tbat", 32'(tbat), 32'h65);

        // ADC stops answering the current channel.
        no_eoc_i = 1'b1;
        k = 0;
        while (!adc_err && k < 500) begin @(posedge clk); #2; k++; end
        check_eq("p3_err_set", 32'(adc_err), 32'd1);
        check_eq("p3_ibat_hold", 32'(ibat), 32'h66);
        wait_upd(1, 300);
        check_eq("p3_err_sticky", 32'(adc_err), 32'd1);

        // Drop en while waiting on a temperature conversion.
        k = 0;
        while (!(adc.adc_start && adc.adc_sel == 2'd2) && k < 600) begin @(negedge clk); k++; end
        check_eq("p4_t_start_seen", 32'(adc.adc_start && adc.adc_sel == 2'd2), 32'd1);
        @(posedge clk); #2;
        en = 1'b0; vsave = vbat; tsave = tbat;
        @(posedge clk); #2;
        check_eq("p4_start_low", 32'(adc.adc_start), 32'd0);
        check_eq("p4_sel_none", 32'(adc.adc_sel), 32'd3);
        check_eq("p4_vtok_low", 32'(vtok), 32'd0);
        repeat (8) @(posedge clk);
        #2;
        check_eq("p4_vbat_hold", 32'(vbat), 32'(vsave));
        check_eq("p4_tbat_hold", 32'(tbat), 32'(tsave));
        check_eq("p4_sel_idle", 32'(adc.adc_sel), 32'd3);
        check_eq("p4_err_sticky", 32'(adc_err), 32'd1);

        // Asynchronous reset in the middle of SETTLE.
        no_eoc_i = 1'b0;
        en = 1'b1;
        k = 0;
        while (adc.adc_sel == 2'd3 && k < 50) begin @(posedge clk); #2; k++; end
        check_eq("p5_selected", 32'(adc.adc_sel != 2'd3), 32'd1);
        rstz = 1'b0;
        #1;
        check_eq("p5_vbat", 32'(vbat), 32'h00);
        check_eq("p5_ibat", 32'(ibat), 32'h00);
        check_eq("p5_tbat", 32'(tbat), 32'h00);
        check_eq("p5_sel", 32'(adc.adc_sel), 32'd3);
        check_eq("p5_start", 32'(adc.adc_start), 32'd0);
        check_eq("p5_err", 32'(adc_err), 32'd0);
        check_eq("p5_vtok", 32'(vtok), 32'd0);
        check_eq("p5_upd", 32'(data_upd), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rstz = 1'b1;
        wait_upd(1, 200);
        check_eq("p5_vbat_after", 32'(vbat), 32'h99);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
